fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline latch: the consumer of the hazard unit's stall/flush outputs. Owns the PC register, drives the instruction-memory request, selects next PC from the PCSrc encoding, and loads the IF/ID latch. It also returns the tmpPC tag that the hazard unit compares against IDEX_tmpPC and EXMEM_tmpPC.

---
 rtl/fetch_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus IF/ID pipeline latch. Owns the PC, issues the
//   instruction-memory read, picks the next PC from PCSrc, and loads IF/ID.
//   It also returns the tmpPC tag, which is the PCSrc that chose each PC, for
//   the hazard unit.
//
//   Optional feature macro: FETCH_REDIRECT_BUFFER_EN
//     When this macro is defined, a redirect that arrives while stall_PC=1 is
//     parked in a pending register. It is applied on the first unstalled edge.
//     When the macro is undefined, such a redirect is dropped.
//
// Parameters
//   PC_INIT       PC value loaded on reset.
// Ports
//   CLK, nRST     rising-edge clock; asynchronous active-low reset
//   ihit          imem has valid data for imemaddr this cycle
//   imemload      instruction word (valid when ihit=1)
//   imemREN       instruction read request (FETCH state only)
//   imemaddr      fetch address = PC register
//   stall_PC      hold PC
//   stall_IFID    hold IF/ID latch
//   flush_IFID    bubble into IF/ID (wins over stall_IFID)
//   PCSrc         00 PC+4, 01 branch, 10 jr, 11 jump
//   branch_target, jr_target, jump_target   redirect addresses
//   halt          halt decoded in ID
//   instr_IFID, npc_IFID, tmpPC_IFID, valid_IFID   IF/ID latch contents
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   input  logic        stall_PC,
   input  logic        stall_IFID,
   input  logic        flush_IFID,
   input  logic [1:0]  PCSrc,
   input  logic [31:0] branch_target,
   input  logic [31:0] jr_target,
   input  logic [31:0] jump_target,
   input  logic        halt,
   output logic [31:0] instr_IFID,
   output logic [31:0] npc_IFID,
   output logic [1:0]  tmpPC_IFID,
   output logic        valid_IFID
);

   typedef enum logic [1:0] {BOOT, FETCH, HALTED} state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] npc;
      logic [1:0]  tmp;
      logic        valid;
   } ifid_t;

   localparam ifid_t IFID_BUBBLE = '{instr: 32'h0, npc: 32'h0, tmp: 2'b00, valid: 1'b0};

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [1:0]  tmppc_q, tmppc_d;
   ifid_t       ifid_q, ifid_d;

   logic        in_fetch;
   logic        redirect_now;   // PCSrc requests a redirect this cycle
   logic        take_redir;     // the new redirect is applied at this edge
   logic        take_pend;      // the buffered redirect is applied at this edge
   logic [31:0] pc_plus4;
   logic [31:0] redir_tgt;

   logic        pend_vld;
   logic [31:0] pend_tgt;
   logic [1:0]  pend_src;

   assign in_fetch     = (state_q == FETCH);
   assign redirect_now = (PCSrc != 2'b00);
   assign pc_plus4     = pc_q + 32'd4;   // wraps modulo 2^32

   always_comb begin
      redir_tgt = branch_target;
      case (PCSrc)
         2'b01:   redir_tgt = branch_target;
         2'b10:   redir_tgt = jr_target;
         2'b11:   redir_tgt = jump_target;
         default: redir_tgt = branch_target;
      endcase
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state_q <= BOOT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:    state_d = FETCH;
         FETCH:   if (halt) state_d = HALTED;
         HALTED:  state_d = HALTED;   // only reset leaves HALTED
         default: state_d = BOOT;
      endcase
   end

   always_comb begin
      imemREN = 1'b0;
      case (state_q)
         FETCH:   imemREN = 1'b1;
         default: imemREN = 1'b0;
      endcase
   end

   // ---------------------------------------------------------- redirect buffer
`ifdef FETCH_REDIRECT_BUFFER_EN
   logic        pend_vld_q, pend_vld_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;
   logic [1:0]  pend_src_q, pend_src_d;

   always_comb begin
      pend_vld_d = pend_vld_q;
      pend_tgt_d = pend_tgt_q;
      pend_src_d = pend_src_q;
      if (in_fetch) begin
         if (redirect_now && stall_PC) begin
            // a newer redirect simply overwrites any older pending one
            pend_vld_d = 1'b1;
            pend_tgt_d = redir_tgt;
            pend_src_d = PCSrc;
         end else if (!stall_PC) begin
            // the pending entry is either applied now or superseded by a live redirect
            pend_vld_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         pend_vld_q <= 1'b0;
         pend_tgt_q <= 32'h0;
         pend_src_q <= 2'b00;
      end else begin
         pend_vld_q <= pend_vld_d;
         pend_tgt_q <= pend_tgt_d;
         pend_src_q <= pend_src_d;
      end
   end

   assign pend_vld = pend_vld_q;
   assign pend_tgt = pend_tgt_q;
   assign pend_src = pend_src_q;
`else
   assign pend_vld = 1'b0;
   assign pend_tgt = 32'h0;
   assign pend_src = 2'b00;
`endif

   // ---------------------------------------------------------------- PC
   always_comb begin
      pc_d       = pc_q;
      tmppc_d    = tmppc_q;
      take_redir = in_fetch && redirect_now && !stall_PC;
      take_pend  = in_fetch && pend_vld && !redirect_now && !stall_PC;
      if (take_redir) begin
         // this abandons the in-flight request, so ihit does not matter here
         pc_d    = redir_tgt;
         tmppc_d = PCSrc;
      end else if (take_pend) begin
         pc_d    = pend_tgt;
         tmppc_d = pend_src;
      end else if (in_fetch && ihit && !stall_PC) begin
         pc_d    = pc_plus4;
         tmppc_d = 2'b00;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         pc_q    <= PC_INIT;
         tmppc_q <= 2'b00;
      end else begin
         pc_q    <= pc_d;
         tmppc_q <= tmppc_d;
      end
   end

   assign imemaddr = pc_q;

   // ---------------------------------------------------------------- IF/ID
   always_comb begin
      ifid_d = IFID_BUBBLE;
      if (state_q == HALTED) begin
         ifid_d = ifid_q;                     // the pipeline front end is frozen
      end else if (flush_IFID) begin
         ifid_d = IFID_BUBBLE;
      end else if (stall_IFID) begin
         ifid_d = ifid_q;
      end else if (in_fetch && ihit && !redirect_now && !take_pend) begin
         // the word at the current PC is wrong-path once any redirect takes effect
         ifid_d.instr = imemload;
         ifid_d.npc   = pc_plus4;
         ifid_d.tmp   = tmppc_q;
         ifid_d.valid = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) ifid_q <= IFID_BUBBLE;
      else       ifid_q <= ifid_d;
   end

   assign instr_IFID = ifid_q.instr;
   assign npc_IFID   = ifid_q.npc;
   assign tmpPC_IFID = ifid_q.tmp;
   assign valid_IFID = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   logic        CLK, nRST, ihit, imemREN, stall_PC, stall_IFID, flush_IFID, halt, valid_IFID;
   logic [31:0] imemload, imemaddr, branch_target, jr_target, jump_target, instr_IFID, npc_IFID;
   logic [1:0]  PCSrc, tmpPC_IFID;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] i;
      logic [31:0] n;
      logic [1:0]  t;
   } exp_t;
   exp_t sb[$];

   fetch_stage #(.PC_INIT(32'h100)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .imemREN(imemREN),
      .imemaddr(imemaddr), .stall_PC(stall_PC), .stall_IFID(stall_IFID),
      .flush_IFID(flush_IFID), .PCSrc(PCSrc), .branch_target(branch_target),
      .jr_target(jr_target), .jump_target(jump_target), .halt(halt),
      .instr_IFID(instr_IFID), .npc_IFID(npc_IFID), .tmpPC_IFID(tmpPC_IFID),
      .valid_IFID(valid_IFID)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // instruction memory model: returns a distinct word for every address
   always_comb imemload = word(imemaddr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Issue one clock edge. If ev is set, push the IF/ID contents expected after
   // the edge (an instruction fetched from address ea) to the scoreboard, then
   // check the fetch-side outputs.
   task automatic step(input bit ev, input logic [31:0] ea, input logic [1:0] et,
                       input logic [31:0] eaddr, input bit eren);
      exp_t e;
      if (ev) begin
         e.i = word(ea);
         e.n = ea + 32'd4;
         e.t = et;
         sb.push_back(e);
      end
      @(posedge CLK); #1;
      chk("imemaddr", imemaddr, eaddr);
      chk("imemREN", {31'b0, imemREN}, {31'b0, eren});
      chk("valid_IFID", {31'b0, valid_IFID}, {31'b0, ev});
   endtask

   // scoreboard monitor: every valid IF/ID presentation consumes one expectation
   always @(negedge CLK) begin
      exp_t e;
      if (nRST && valid_IFID) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got instr %h with no expectation at %0t", instr_IFID, $time);
         end else begin
            e = sb.pop_front();
            chk("instr_IFID", instr_IFID, e.i);
            chk("npc_IFID", npc_IFID, e.n);
            chk("tmpPC_IFID", {30'b0, tmpPC_IFID}, {30'b0, e.t});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   logic [31:0] haddr;

   initial begin
      nRST = 1'b1; ihit = 0; stall_PC = 0; stall_IFID = 0; flush_IFID = 0; halt = 0;
      PCSrc = 2'b00; branch_target = 0; jr_target = 0; jump_target = 0;
      #1 nRST = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_imemaddr", imemaddr, 32'h100);
      chk("rst_imemREN", {31'b0, imemREN}, 32'd0);
      chk("rst_valid", {31'b0, valid_IFID}, 32'd0);
      chk("rst_instr", instr_IFID, 32'd0);
      chk("rst_npc", npc_IFID, 32'd0);
      chk("rst_tmpPC", {30'b0, tmpPC_IFID}, 32'd0);

      nRST = 1'b1; ihit = 1;
      step(0, 0, 2'b00, 32'h100, 1);           // BOOT cycle
      step(1, 32'h100, 2'b00, 32'h104, 1);
      ihit = 0;
      repeat (3) step(0, 0, 2'b00, 32'h104, 1); // waiting on imem
      ihit = 1;
      step(1, 32'h104, 2'b00, 32'h108, 1);
      step(1, 32'h108, 2'b00, 32'h10C, 1);

      // branch with flush, no ihit
      ihit = 0; PCSrc = 2'b01; branch_target = 32'h200; flush_IFID = 1;
      step(0, 0, 2'b00, 32'h200, 1);
      PCSrc = 2'b00; flush_IFID = 0; ihit = 1;
      step(1, 32'h200, 2'b01, 32'h204, 1);
      step(1, 32'h204, 2'b00, 32'h208, 1);

      // jr with ihit high: redirect drops the wrong-path word
      PCSrc = 2'b10; jr_target = 32'h300;
      step(0, 0, 2'b00, 32'h300, 1);
      PCSrc = 2'b00;
      step(1, 32'h300, 2'b10, 32'h304, 1);

      // flush beats stall
      ihit = 0; stall_IFID = 1; flush_IFID = 1;
      step(0, 0, 2'b00, 32'h304, 1);
      chk("flush_instr", instr_IFID, 32'd0);
      chk("flush_npc", npc_IFID, 32'd0);
      stall_IFID = 0; flush_IFID = 0; ihit = 1;
      step(1, 32'h304, 2'b00, 32'h308, 1);
      stall_IFID = 1; stall_PC = 1;
      step(1, 32'h304, 2'b00, 32'h308, 1);       // held
      step(1, 32'h304, 2'b00, 32'h308, 1);       // held
      stall_IFID = 0; stall_PC = 0;
      step(1, 32'h308, 2'b00, 32'h30C, 1);

      // PC wrap
      ihit = 0; PCSrc = 2'b11; jump_target = 32'hFFFF_FFFC;
      step(0, 0, 2'b00, 32'hFFFF_FFFC, 1);
      PCSrc = 2'b00; ihit = 1;
      step(1, 32'hFFFF_FFFC, 2'b11, 32'h0, 1);
      step(1, 32'h0, 2'b00, 32'h4, 1);

      // redirect while PC stalled
      ihit = 0; PCSrc = 2'b11; jump_target = 32'h40; stall_PC = 1;
      step(0, 0, 2'b00, 32'h4, 1);
      PCSrc = 2'b00; stall_PC = 0; ihit = 1;
`ifdef FETCH_REDIRECT_BUFFER_EN
      step(0, 0, 2'b00, 32'h40, 1);
      step(1, 32'h40, 2'b11, 32'h44, 1);
      haddr = 32'h44;
`else
      step(1, 32'h4, 2'b00, 32'h8, 1);
      step(1, 32'h8, 2'b00, 32'hC, 1);
      haddr = 32'hC;
`endif

      // halt
      ihit = 0; halt = 1;
      step(0, 0, 2'b00, haddr, 0);
      halt = 0; ihit = 1; PCSrc = 2'b01; branch_target = 32'h500;
      repeat (2) step(0, 0, 2'b00, haddr, 0);    // frozen
      PCSrc = 2'b00;

      // asynchronous reset mid-cycle
      #2 nRST = 1'b0;
      #1;
      chk("arst_imemaddr", imemaddr, 32'h100);
      chk("arst_imemREN", {31'b0, imemREN}, 32'd0);
      chk("arst_valid", {31'b0, valid_IFID}, 32'd0);
      @(posedge CLK); #1;
      nRST = 1'b1;
      step(0, 0, 2'b00, 32'h100, 1);             // BOOT again
      step(1, 32'h100, 2'b00, 32'h104, 1);
      ihit = 0;
      step(0, 0, 2'b00, 32'h104, 1);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
